// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer: feeds an external 1-bit ALU one operand bit per cycle, LSB first.
// Defining ALU_SEQ_ABORT_EN adds an i_abort input that cancels a running operation.
module alu_bitserial_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef ALU_SEQ_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_ready,
  output logic             o_alu_a,
  output logic             o_alu_b,
  output logic             o_alu_cin,
  output logic [1:0]       o_alu_op,
  input  logic             i_alu_result,
  input  logic             i_alu_cout,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_done
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_carry;
  logic [IdxW-1:0]  r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic [WIDTH-1:0] r_saved_result;
  logic             r_saved_cout;
  logic [WIDTH-1:0] w_mask;
  logic             w_abort;
  logic             w_run;
  logic             w_accept;

`ifdef ALU_SEQ_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_run    = (r_state == StRun);
  assign w_accept = (r_state == StIdle) && i_start;
  assign w_mask   = {{(WIDTH-1){1'b0}}, 1'b1} << r_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StRun;
      end
      StRun: begin
        if (w_abort) begin
          w_state_next = StIdle;
        end else if (r_idx == LastIdx) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_ready   = (r_state == StIdle);
    o_done    = (r_state == StDone);
    o_alu_a   = w_run & r_a[0];
    o_alu_b   = w_run & r_b[0];
    o_alu_cin = w_run & r_carry;
    o_alu_op  = r_op;
    o_result  = r_result;
    o_cout    = r_cout;
  end

  // Operands shift right so bit 0 is always the current bit; result bits are
  // written in place so untouched bits keep their previous value during RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a            <= '0;
      r_b            <= '0;
      r_op           <= 2'b00;
      r_carry        <= 1'b0;
      r_idx          <= '0;
      r_result       <= '0;
      r_cout         <= 1'b0;
      r_saved_result <= '0;
      r_saved_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a            <= i_a;
      r_b            <= i_b;
      r_op           <= i_op;
      r_carry        <= i_cin;
      r_idx          <= '0;
      r_saved_result <= r_result;
      r_saved_cout   <= r_cout;
    end else if (w_run) begin
      if (w_abort) begin
        r_result <= r_saved_result;
        r_cout   <= r_saved_cout;
      end else begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_carry  <= i_alu_cout;
        r_result <= (r_result & ~w_mask) | (w_mask & {WIDTH{i_alu_result}});
        if (r_idx == LastIdx) begin
          r_cout <= i_alu_cout;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Self-checking bench for alu_bitserial_seq wired to a behavioural 1-bit ALU.
// Build with ALU_SEQ_ABORT_EN defined to exercise the abort path.
module tb_alu_bitserial_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef ALU_SEQ_ABORT_EN
  logic         abort;
`endif
  logic         ready;
  logic         alu_a;
  logic         alu_b;
  logic         alu_cin;
  logic [1:0]   alu_op;
  logic         alu_res;
  logic         alu_co;
  logic [W-1:0] result;
  logic         cout;
  logic         done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_op         (op),
    .i_a          (a),
    .i_b          (b),
    .i_cin        (cin),
`ifdef ALU_SEQ_ABORT_EN
    .i_abort      (abort),
`endif
    .o_ready      (ready),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_cin    (alu_cin),
    .o_alu_op     (alu_op),
    .i_alu_result (alu_res),
    .i_alu_cout   (alu_co),
    .o_result     (result),
    .o_cout       (cout),
    .o_done       (done)
  );

  // 1-bit ALU: 00 add, 01 subtract (a + ~b + cin), 10 and, 11 xor; logic ops pass carry through.
  always_comb begin
    case (alu_op)
      2'b00: begin
        alu_res = alu_a ^ alu_b ^ alu_cin;
        alu_co  = (alu_a & alu_b) | (alu_a & alu_cin) | (alu_b & alu_cin);
      end
      2'b01: begin
        alu_res = alu_a ^ ~alu_b ^ alu_cin;
        alu_co  = (alu_a & ~alu_b) | (alu_a & alu_cin) | (~alu_b & alu_cin);
      end
      2'b10: begin
        alu_res = alu_a & alu_b;
        alu_co  = alu_cin;
      end
      default: begin
        alu_res = alu_a ^ alu_b;
        alu_co  = alu_cin;
      end
    endcase
  end

  // Word-level reference: returns {cout, result}.
  function automatic logic [W:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y, input logic c);
    logic [W:0] s;
    case (o)
      2'b00:   s = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      2'b01:   s = {1'b0, x} + {1'b0, ~y} + (W+1)'(c);
      2'b10:   s = {c, x & y};
      default: s = {c, x ^ y};
    endcase
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns just after the accepting edge.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c);
    op = o; a = x; b = y; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    tick(); tick();
    rst = 1'b0; start = 1'b0;
    n_vec++;
    if ({ready, done, result, cout, alu_a, alu_b, alu_cin, alu_op} !== {2'b10, {W{1'b0}}, 6'b0}) begin
      n_bad++;
      $display("FAIL reset: rdy=%b done=%b res=%h cout=%b a=%b b=%b cin=%b op=%b, want rdy=1 rest 0",
               ready, done, result, cout, alu_a, alu_b, alu_cin, alu_op);
    end
  endtask

  task automatic test_bit_sequence();
    logic [W-1:0] av, bv;
    logic [W:0]   exp;
    logic         ec;
    av = 8'hA5; bv = 8'h3C;
    launch(2'b00, av, bv, 1'b1);
    for (int k = 0; k < W; k++) begin
      ec = 1'((({1'b0, av} & ((9'd1 << k) - 1)) + ({1'b0, bv} & ((9'd1 << k) - 1)) + 9'd1) >> k);
      n_vec++;
      if ({alu_a, alu_b, alu_cin, ready} !== {av[k], bv[k], ec, 1'b0}) begin
        n_bad++;
        $display("FAIL bitseq k=%0d: a/b/cin/rdy=%b%b%b%b want %b%b%b0",
                 k, alu_a, alu_b, alu_cin, ready, av[k], bv[k], ec);
      end
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      tick();
    end
    exp = ref_op(2'b00, av, bv, 1'b1);
    n_vec++;
    if ({done, cout, result, alu_a, alu_b, alu_cin} !== {1'b1, exp, 3'b000}) begin
      n_bad++;
      $display("FAIL bitseq_done: done=%b cout=%b res=%h abc=%b%b%b want done=1 %b %h 000",
               done, cout, result, alu_a, alu_b, alu_cin, exp[W], exp[W-1:0]);
    end
    tick();
  endtask

  task automatic test_random_ops();
    logic [W-1:0] av, bv;
    logic         cv;
    logic [W:0]   exp, got;
    int           lat, ndone;
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 64; i++) begin
        av = W'($urandom); bv = W'($urandom); cv = 1'($urandom);
        exp = ref_op(2'(o), av, bv, cv);
        launch(2'(o), av, bv, cv);
        lat = -1; ndone = 0; got = '0;
        for (int n = 1; n <= W + 2; n++) begin
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 2'($urandom);
          tick();
          if (done === 1'b1) begin
            ndone++;
            if (lat < 0) lat = n;
            got = {cout, result};
          end
        end
        n_vec++;
        if (got !== exp || lat != W || ndone != 1) begin
          n_bad++;
          $display("FAIL op%0d a=%h b=%h c=%b: got %h lat=%0d dones=%0d want %h lat=%0d dones=1",
                   o, av, bv, cv, got, lat, ndone, exp, W);
        end
        n_vec++;
        if ({ready, alu_op, alu_a, alu_b, alu_cin} !== {1'b1, 2'(o), 3'b000}) begin
          n_bad++;
          $display("FAIL idle_outs op%0d: rdy=%b op=%b abc=%b%b%b want 1 %b 000",
                   o, ready, alu_op, alu_a, alu_b, alu_cin, 2'(o));
        end
      end
    end
  endtask

  task automatic test_start_held();
    logic [W:0] q[$];
    logic [W:0] exp;
    logic [W-1:0] bv;
    int ndone;
    ndone = 0;
    bv = W'($urandom);
    for (int c = 0; c < 30; c++) begin
      start = (c < 20);
      a = W'($urandom); b = bv; cin = 1'b0; op = 2'b00;
      if (c < 20 && c % (W + 2) == 0) q.push_back(ref_op(2'b00, a, bv, 1'b0));
      tick();
      if (done === 1'b1) begin
        ndone++;
        exp = (q.size() > 0) ? q.pop_front() : '1;
        n_vec++;
        if ({cout, result} !== exp) begin
          n_bad++;
          $display("FAIL held_start result #%0d: got %h want %h", ndone, {cout, result}, exp);
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (ndone != 2 || q.size() != 0) begin
      n_bad++;
      $display("FAIL held_start count: dones=%0d pending=%0d want 2 and 0", ndone, q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    launch(2'b00, 8'hF0, 8'h0F, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({ready, done, result, cout} !== {2'b10, {W{1'b0}}, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_mid_run: rdy=%b done=%b res=%h cout=%b want 1 0 00 0",
               ready, done, result, cout);
    end
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    n_vec++;
    if (ndone != 0) begin
      n_bad++;
      $display("FAIL rst_mid_run_done: dones=%0d want 0", ndone);
    end
  endtask

  task automatic test_abort();
    int ndone;
    logic [W:0] exp;
    launch(2'b11, 8'h5A, 8'h00, 1'b0);
    for (int n = 0; n < W + 2; n++) tick();
    n_vec++;
    if ({cout, result} !== {1'b0, 8'h5A}) begin
      n_bad++;
      $display("FAIL abort_prior: got %h want 05a", {cout, result});
    end
    exp = ref_op(2'b00, 8'hC3, 8'h7E, 1'b1);
    launch(2'b00, 8'hC3, 8'h7E, 1'b1);
    tick(); tick(); tick(); tick();
`ifdef ALU_SEQ_ABORT_EN
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_vec++;
    if ({ready, done, cout, result} !== {2'b10, 1'b0, 8'h5A}) begin
      n_bad++;
      $display("FAIL abort: rdy=%b done=%b cout=%b res=%h want 1 0 0 5a",
               ready, done, cout, result);
    end
    ndone = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    n_vec++;
    if (ndone != 0) begin
      n_bad++;
      $display("FAIL abort_done: dones=%0d want 0", ndone);
    end
`else
    ndone = 0;
    for (int n = 0; n < W; n++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    n_vec++;
    if (ndone != 1 || {cout, result} !== exp || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL no_abort: dones=%0d got %h rdy=%b want 1 %h 1", ndone, {cout, result},
               ready, exp);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
`ifdef ALU_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_bit_sequence();
    test_random_ops();
    test_start_held();
    test_reset_mid_run();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_bitserial_seq.md
ALU_BITSERIAL_SEQ -- requirements
Module: alu_bitserial_seq

Interface
REQ-001 Parameter WIDTH, default 8, number of operand bits processed per operation; legal range 2..32.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  in  1  request to begin an operation; accepted only when ready=1.
REQ-005 op_in  in  2  operation code, forwarded unchanged to the 1-bit ALU for every bit.
REQ-006 a_in, b_in  in  WIDTH  operands, latched on start acceptance.
REQ-007 cin_in  in  1  carry into bit 0, latched on start acceptance.
REQ-008 ready  out  1  high only in IDLE.
REQ-009 alu_a, alu_b, alu_cin  out  1  bit operands and carry driven to the external 1-bit ALU.
REQ-010 alu_op  out  2  op code driven to the 1-bit ALU.
REQ-011 alu_result, alu_cout  in  1  combinational outputs returned from the 1-bit ALU.
REQ-012 result_out  out  WIDTH  assembled result; cout_out  out  1  final carry.
REQ-013 done  out  1  single-cycle pulse marking result_out/cout_out valid.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start&&ready; RUN->DONE after WIDTH RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-015 On acceptance, a_in, b_in, op_in, cin_in are registered; later changes on these inputs do not affect the running operation.
REQ-016 RUN processes bits LSB first; in RUN cycle k (k=0..WIDTH-1), alu_a=a[k], alu_b=b[k], alu_op=latched op.
REQ-017 alu_cin = latched cin in RUN cycle 0; in cycle k>0 it equals alu_cout registered at the end of cycle k-1.
REQ-018 alu_result in RUN cycle k is captured into result bit k at the end of that cycle; alu_cout of the last RUN cycle is captured into cout_out.
REQ-019 Bit index counter is $clog2(WIDTH) bits, cleared on acceptance, wraps never: transition to DONE occurs when index = WIDTH-1.
REQ-020 Latency: start accepted at edge T -> done high during the cycle following edge T+WIDTH; ready high again after edge T+WIDTH+1.
REQ-021 result_out and cout_out hold their values from DONE until the next operation writes them; they are not altered during RUN beyond the bit being written.
REQ-022 start asserted in RUN or DONE is ignored, not queued.
REQ-023 Outside RUN, alu_a, alu_b, alu_cin drive 0 and alu_op drives the last latched op.

Reset
REQ-024 rst forces IDLE on the next edge, overriding start and any in-flight operation (reset mid-RUN discards it, no done).
REQ-025 Reset values: ready=1 (after reset edge), done=0, result_out=0, cout_out=0, alu_a/alu_b/alu_cin=0, alu_op=2'b00, counter=0.

Configuration
REQ-026 Macro ALU_SEQ_ABORT_EN, when defined, adds input abort (1 bit); abort=1 in RUN returns FSM to IDLE next edge, no done pulse, result_out/cout_out restored to their pre-operation values.
REQ-027 abort is ignored in IDLE and DONE; rst has priority over abort.
REQ-028 Without ALU_SEQ_ABORT_EN, the abort port does not exist and every accepted operation runs to DONE.

Verification
REQ-029 WIDTH=8, a_in=8'hA5, b_in=8'h3C, cin_in=1, start one cycle -> alu_a sequence 1,0,1,0,0,1,0,1; alu_b 0,0,1,1,1,1,0,0; alu_cin=1 in cycle 0.
REQ-030 Sequencer wired to the team's alu_1bit, all 4 op codes, 64 random operand pairs each -> result_out/cout_out equal a bench model chaining alu_1bit WIDTH times; done exactly once per op, 9 cycles after acceptance.
REQ-031 start held high for 20 cycles with a_in changing every cycle -> exactly one op per IDLE visit, using operands sampled at acceptance only.
REQ-032 rst asserted in RUN cycle 3 -> next cycle ready=1, done never pulses, result_out=0.
REQ-033 ALU_SEQ_ABORT_EN defined, prior result 8'h5A, abort in RUN cycle 4 -> ready=1 next cycle, no done, result_out remains 8'h5A; macro undefined -> same op completes normally.
